// File: rtl/semaforo_pkg.sv
// Shared types and default timing for the round-robin traffic-light controller.
package semaforo_pkg;

    typedef enum logic [1:0] {
        ROJO_TODO = 2'd0,
        VERDE     = 2'd1,
        AMBAR     = 2'd2,
        PARPADEO  = 2'd3
    } state_t;

    localparam int unsigned N_WAYS_DEF      = 2;
    localparam int unsigned T_VERDE_DEF     = 8;
    localparam int unsigned T_VERDE_MIN_DEF = 3;
    localparam int unsigned T_AMBAR_DEF     = 3;
    localparam int unsigned T_ROJO_DEF      = 1;
    localparam int unsigned T_PARP_DEF      = 2;

    function automatic int unsigned max2(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    // Bits needed to count 0..maxv-1.
    function automatic int unsigned cnt_width(input int unsigned maxv);
        return (maxv > 1) ? $clog2(maxv) : 1;
    endfunction

endpackage

// File: rtl/semaforo_if.sv
// Control inputs and lamp outputs of the traffic-light controller.
interface semaforo_if #(
    parameter int unsigned N_WAYS = 2
);
    localparam int unsigned FW = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

    logic              en;
    logic              t;
    logic [N_WAYS-1:0] ped_req;
    logic [N_WAYS-1:0] v;
    logic [N_WAYS-1:0] a;
    logic [N_WAYS-1:0] r;
    logic              b;
    logic [FW-1:0]     fase;

    modport master (output en, t, ped_req, input v, a, r, b, fase);
    modport slave  (input en, t, ped_req, output v, a, r, b, fase);
endinterface

// File: rtl/semaforo_timer.sv
// Tick counter with clear (priority) and terminal-count compare.
module semaforo_timer #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] cnt,
    output logic          done_c
);

    // Count ticks; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done_c = (cnt == term);

endmodule

// File: rtl/semaforo_param.sv
// Round-robin traffic-light controller with request-driven early green cut-off and blink mode.
module semaforo_param
    import semaforo_pkg::*;
#(
    parameter int unsigned N_WAYS      = N_WAYS_DEF,
    parameter int unsigned T_VERDE     = T_VERDE_DEF,
    parameter int unsigned T_VERDE_MIN = T_VERDE_MIN_DEF,
    parameter int unsigned T_AMBAR     = T_AMBAR_DEF,
    parameter int unsigned T_ROJO      = T_ROJO_DEF,
    parameter int unsigned T_PARP      = T_PARP_DEF
) (
    input logic       clk,
    input logic       rst,
    semaforo_if.slave bus
);

    localparam int unsigned FW = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int unsigned CW = cnt_width(max2(max2(T_VERDE, T_AMBAR), max2(T_ROJO, T_PARP)));

    state_t            state, state_nxt;
    logic [FW-1:0]     k, k_nxt;
    logic [N_WAYS-1:0] req, req_nxt;
    logic              blink_a, blink_a_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     term;
    logic              done_c;
    logic              clr;
    logic              others_req;
    logic [N_WAYS-1:0] sel;
    logic [N_WAYS-1:0] sel_nxt;

    semaforo_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (bus.t),
        .term   (term),
        .cnt    (cnt),
        .done_c (done_c)
    );

    assign sel        = N_WAYS'(1) << k;
    assign sel_nxt    = N_WAYS'(1) << k_nxt;
    assign others_req = |(req & ~sel);

    // Terminal count for the current state.
    always_comb begin
        term = CW'(T_ROJO - 1);
        case (state)
            VERDE:    term = CW'(T_VERDE - 1);
            AMBAR:    term = CW'(T_AMBAR - 1);
            PARPADEO: term = CW'(T_PARP - 1);
            default:  term = CW'(T_ROJO - 1);
        endcase
    end

    // Next state, way index, blink phase and timer clear.
    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        blink_a_nxt = blink_a;
        clr         = 1'b0;
        case (state)
            ROJO_TODO: begin
                if (bus.t && done_c) begin
                    state_nxt = bus.en ? VERDE : PARPADEO;
                    clr       = 1'b1;
                end
            end
            VERDE: begin
                if (bus.t && (done_c || !bus.en ||
                              ((cnt >= CW'(T_VERDE_MIN - 1)) && others_req))) begin
                    state_nxt = AMBAR;
                    clr       = 1'b1;
                end
            end
            AMBAR: begin
                if (bus.t && done_c) begin
                    state_nxt = ROJO_TODO;
                    k_nxt     = (k == FW'(N_WAYS - 1)) ? '0 : k + FW'(1);
                    clr       = 1'b1;
                end
            end
            PARPADEO: begin
                if (bus.en) begin
                    state_nxt   = ROJO_TODO;
                    k_nxt       = '0;
                    blink_a_nxt = 1'b0;
                    clr         = 1'b1;
                end else if (bus.t && done_c) begin
                    blink_a_nxt = ~blink_a;
                    clr         = 1'b1;
                end
            end
            default: begin
                state_nxt = ROJO_TODO;
                clr       = 1'b1;
            end
        endcase
    end

    // Request latch: entering green for a way clears its request, overriding a new one.
    always_comb begin
        req_nxt = req | bus.ped_req;
        if (state == ROJO_TODO && state_nxt == VERDE) begin
            req_nxt = req_nxt & ~sel;
        end
    end

    // State registers and lamps decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ROJO_TODO;
            k        <= '0;
            req      <= '0;
            blink_a  <= 1'b0;
            bus.v    <= '0;
            bus.a    <= '0;
            bus.r    <= '1;
            bus.b    <= 1'b0;
            bus.fase <= '0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            req      <= req_nxt;
            blink_a  <= blink_a_nxt;
            bus.v    <= (state_nxt == VERDE) ? sel_nxt : '0;
            bus.a    <= (state_nxt == AMBAR)    ? sel_nxt :
                        (state_nxt == PARPADEO) ? {N_WAYS{blink_a_nxt}} : '0;
            bus.r    <= (state_nxt == PARPADEO)  ? '0 :
                        (state_nxt == ROJO_TODO) ? '1 : ~sel_nxt;
            bus.b    <= (state_nxt == PARPADEO);
            bus.fase <= k_nxt;
        end
    end

endmodule

// File: tb/tb_semaforo_param.sv
// Directed self-checking bench for semaforo_param (3 ways, short timings).
module tb_semaforo_param;

    localparam int KR = 0;
    localparam int KV = 1;
    localparam int KA = 2;
    localparam int KP = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    semaforo_if #(.N_WAYS(3)) bus ();

    semaforo_param #(
        .N_WAYS      (3),
        .T_VERDE     (4),
        .T_VERDE_MIN (2),
        .T_AMBAR     (2),
        .T_ROJO      (1),
        .T_PARP      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {r, a, v, b, fase} for a lamp situation.
    function automatic logic [11:0] lamp(input int kind, input int w, input logic ba);
        logic [2:0] oh;
        logic [1:0] f;
        oh = 3'(1 << w);
        f  = 2'(w);
        case (kind)
            KV:      return {~oh, 3'b000, oh, 1'b0, f};
            KA:      return {~oh, oh, 3'b000, 1'b0, f};
            KP:      return {3'b000, {3{ba}}, 3'b000, 1'b1, f};
            default: return {3'b111, 3'b000, 3'b000, 1'b0, f};
        endcase
    endfunction

    function automatic logic [11:0] obs();
        return {bus.r, bus.a, bus.v, bus.b, bus.fase};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst         = 1'b0;
        bus.en      = 1'b1;
        bus.t       = 1'b1;
        bus.ped_req = 3'b000;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        bus.en      = 1'b1;
        bus.t       = 1'b1;
        bus.ped_req = 3'b000;
        step();
        step();
        checks++; if (bus.r !== 3'b111) begin errors++; $display("FAIL reset_r got=%b exp=111", bus.r); end
        checks++; if (bus.v !== 3'b000) begin errors++; $display("FAIL reset_v got=%b exp=000", bus.v); end
        checks++; if (bus.a !== 3'b000) begin errors++; $display("FAIL reset_a got=%b exp=000", bus.a); end
        checks++; if (bus.b !== 1'b0) begin errors++; $display("FAIL reset_b got=%b exp=0", bus.b); end
        checks++; if (bus.fase !== 2'd0) begin errors++; $display("FAIL reset_fase got=%0d exp=0", bus.fase); end
    endtask

    task automatic test_cycle();
        logic [11:0] exp_q[$];
        reset_dut();
        for (int w = 0; w < 3; w++) begin
            repeat (4) exp_q.push_back(lamp(KV, w, 1'b0));
            repeat (2) exp_q.push_back(lamp(KA, w, 1'b0));
            exp_q.push_back(lamp(KR, (w + 1) % 3, 1'b0));
        end
        exp_q.push_back(lamp(KV, 0, 1'b0));
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            checks++;
            if (obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL cycle i=%0d got=%h exp=%h", i, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_early_cutoff();
        logic [11:0] exp_q[$];
        reset_dut();
        step();
        checks++; if (obs() !== lamp(KV, 0, 1'b0)) begin errors++; $display("FAIL early_v0a got=%h exp=%h", obs(), lamp(KV, 0, 1'b0)); end
        bus.ped_req = 3'b100;
        step();
        bus.ped_req = 3'b000;
        checks++; if (obs() !== lamp(KV, 0, 1'b0)) begin errors++; $display("FAIL early_v0b got=%h exp=%h", obs(), lamp(KV, 0, 1'b0)); end
        repeat (2) exp_q.push_back(lamp(KA, 0, 1'b0));
        exp_q.push_back(lamp(KR, 1, 1'b0));
        repeat (2) exp_q.push_back(lamp(KV, 1, 1'b0));
        repeat (2) exp_q.push_back(lamp(KA, 1, 1'b0));
        exp_q.push_back(lamp(KR, 2, 1'b0));
        repeat (4) exp_q.push_back(lamp(KV, 2, 1'b0));
        exp_q.push_back(lamp(KA, 2, 1'b0));
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            checks++;
            if (obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL early i=%0d got=%h exp=%h", i, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_blink();
        logic [11:0] exp_q[$];
        reset_dut();
        repeat (8) step();
        checks++; if (obs() !== lamp(KV, 1, 1'b0)) begin errors++; $display("FAIL blink_anchor got=%h exp=%h", obs(), lamp(KV, 1, 1'b0)); end
        bus.en = 1'b0;
        repeat (2) exp_q.push_back(lamp(KA, 1, 1'b0));
        exp_q.push_back(lamp(KR, 2, 1'b0));
        repeat (2) exp_q.push_back(lamp(KP, 2, 1'b0));
        repeat (2) exp_q.push_back(lamp(KP, 2, 1'b1));
        repeat (2) exp_q.push_back(lamp(KP, 2, 1'b0));
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            checks++;
            if (obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL blink i=%0d got=%h exp=%h", i, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_blink_exit();
        bus.en = 1'b1;
        bus.t  = 1'b0;
        step();
        checks++; if (obs() !== lamp(KR, 0, 1'b0)) begin errors++; $display("FAIL blink_exit_r got=%h exp=%h", obs(), lamp(KR, 0, 1'b0)); end
        bus.t = 1'b1;
        step();
        checks++; if (obs() !== lamp(KV, 0, 1'b0)) begin errors++; $display("FAIL blink_exit_v got=%h exp=%h", obs(), lamp(KV, 0, 1'b0)); end
    endtask

    task automatic test_hold();
        reset_dut();
        repeat (5) step();
        checks++; if (obs() !== lamp(KA, 0, 1'b0)) begin errors++; $display("FAIL hold_anchor got=%h exp=%h", obs(), lamp(KA, 0, 1'b0)); end
        bus.t = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (obs() !== lamp(KA, 0, 1'b0)) begin
                errors++;
                $display("FAIL hold i=%0d got=%h exp=%h", i, obs(), lamp(KA, 0, 1'b0));
            end
        end
        bus.t = 1'b1;
        step();
        checks++; if (obs() !== lamp(KA, 0, 1'b0)) begin errors++; $display("FAIL hold_resume_a got=%h exp=%h", obs(), lamp(KA, 0, 1'b0)); end
        step();
        checks++; if (obs() !== lamp(KR, 1, 1'b0)) begin errors++; $display("FAIL hold_resume_r got=%h exp=%h", obs(), lamp(KR, 1, 1'b0)); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        repeat (15) step();
        checks++; if (obs() !== lamp(KV, 2, 1'b0)) begin errors++; $display("FAIL rmid_v2a got=%h exp=%h", obs(), lamp(KV, 2, 1'b0)); end
        bus.ped_req = 3'b010;
        step();
        bus.ped_req = 3'b000;
        checks++; if (obs() !== lamp(KV, 2, 1'b0)) begin errors++; $display("FAIL rmid_v2b got=%h exp=%h", obs(), lamp(KV, 2, 1'b0)); end
        step();
        checks++; if (obs() !== lamp(KA, 2, 1'b0)) begin errors++; $display("FAIL rmid_a2 got=%h exp=%h", obs(), lamp(KA, 2, 1'b0)); end
        bus.ped_req = 3'b011;
        rst         = 1'b0;
        step();
        checks++; if (obs() !== lamp(KR, 0, 1'b0)) begin errors++; $display("FAIL rmid_reset got=%h exp=%h", obs(), lamp(KR, 0, 1'b0)); end
        rst         = 1'b1;
        bus.ped_req = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs() !== lamp(KV, 0, 1'b0)) begin
                errors++;
                $display("FAIL rmid_green i=%0d got=%h exp=%h", i, obs(), lamp(KV, 0, 1'b0));
            end
        end
        step();
        checks++; if (obs() !== lamp(KA, 0, 1'b0)) begin errors++; $display("FAIL rmid_amber got=%h exp=%h", obs(), lamp(KA, 0, 1'b0)); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        bus.en      = 1'b1;
        bus.t       = 1'b1;
        bus.ped_req = 3'b000;
        test_reset();
        test_cycle();
        test_early_cutoff();
        test_blink();
        test_blink_exit();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/semaforo_param.md
SEMAFORO_PARAM -- requirements
Module: semaforo_param

Interface
REQ-001 The block SHALL have parameter N_WAYS, default 2, number of approaches served round-robin (range 2..8).
REQ-002 The block SHALL have parameter T_VERDE, default 8, full green duration in ticks (>=2).
REQ-003 The block SHALL have parameter T_VERDE_MIN, default 3, minimum green in ticks before early cut-off (1..T_VERDE).
REQ-004 The block SHALL have parameter T_AMBAR, default 3, amber duration in ticks (>=1).
REQ-005 The block SHALL have parameter T_ROJO, default 1, all-red clearance duration in ticks (>=1).
REQ-006 The block SHALL have parameter T_PARP, default 2, blink half-period in ticks (>=1).
REQ-007 CLK  in  1  single clock; all state changes on its rising edge.
REQ-008 RST  in  1  reset, synchronous, active-low.
REQ-009 EN  in  1  1 = normal cycling, 0 = blink (out-of-service) mode.
REQ-010 T  in  1  time-base tick; timers advance only on cycles with T=1.
REQ-011 PED_REQ  in  N_WAYS  per-way service request (pulse or level).
REQ-012 V / A / R  out  N_WAYS each  green / amber / red lamp per way, registered.
REQ-013 B  out  1  1 while in blink mode, registered.
REQ-014 FASE  out  $clog2(N_WAYS)  index of the way currently owning green/amber, or next to be served.

Function
REQ-015 States SHALL be ROJO_TODO, VERDE, AMBAR, PARPADEO; a way index k and a tick counter cnt accompany them.
REQ-016 ROJO_TODO: on a tick with cnt==T_ROJO-1, go to PARPADEO if EN=0, else VERDE with k unchanged; cnt cleared.
REQ-017 VERDE(k): on a tick, go to AMBAR(k) when cnt==T_VERDE-1, or when cnt>=T_VERDE_MIN-1 and a latched request exists for any way j!=k, or when EN=0.
REQ-018 AMBAR(k): on a tick with cnt==T_AMBAR-1, go to ROJO_TODO with k <= (k==N_WAYS-1) ? 0 : k+1.
REQ-019 PARPADEO: A toggles (all ways together) on each tick with cnt==T_PARP-1; on any cycle with EN=1 go to ROJO_TODO with k=0, cnt=0, A=0.
REQ-020 In non-blink states cnt SHALL increment only on T=1 and clear on every state transition; with T=0 all state and outputs hold.
REQ-021 Request latch req[j] SHALL set on PED_REQ[j]=1, and clear on the cycle VERDE(j) is entered (clear wins over set).
REQ-022 Requests SHALL NOT reorder service; round-robin order is fixed.
REQ-023 Lamps: VERDE(k): V[k]=1, R=all-ones except bit k; AMBAR(k): A[k]=1, R except bit k; ROJO_TODO: R all ones, V=A=0; PARPADEO: R=V=0, B=1.
REQ-024 Outside PARPADEO at most one bit of V|A SHALL be 1 and V&A SHALL be 0 for every way.
REQ-025 Lamp outputs SHALL reflect the state registered at the same edge (no combinational path from inputs).

Reset
REQ-026 On a rising edge with RST=0: state ROJO_TODO, k=0, cnt=0, req=0, R=all ones, V=0, A=0, B=0, FASE=0; applies mid-operation from any state.

Structure
REQ-027 Package semaforo_pkg SHALL hold the state enumeration and default duration constants.
REQ-028 One sub-module semaforo_timer (tick counter with terminal-count compare and clear) SHALL be instantiated once.

Verification (N_WAYS=3, T_VERDE=4, T_VERDE_MIN=2, T_AMBAR=2, T_ROJO=1, T_PARP=2, T=1 every cycle unless stated)
REQ-029 Reset then EN=1, no requests -> R=111 1 cycle, V=001 4 cycles, A=001 2, R=111 1, V=010 4, ... V=100, then back to V=001 (wrap).
REQ-030 PED_REQ[2] pulse during VERDE(0) cnt=0 -> A=001 after 2 green cycles; way 1 served next, req[2] held until VERDE(2).
REQ-031 EN=0 during VERDE(1) -> A=010 for 2 cycles, R=111 1 cycle, then B=1, R=V=0, A toggles 000/111 every 2 cycles.
REQ-032 EN=1 during PARPADEO -> next cycle R=111, B=0, then V=001 after 1 tick.
REQ-033 T held 0 for 20 cycles during AMBAR(0) -> all outputs constant; resumes with remaining amber ticks.
REQ-034 RST=0 for one edge mid-AMBAR(2) with PED_REQ asserted -> R=111, V=A=0, B=0, FASE=0; earlier-latched requests cleared.
